// File: rtl/demod_decimator_if.sv
// AXI-Stream bundle for the demod decimator: mixed samples in,
// decimated channel-tagged means out.
interface demod_decimator_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [1:0]        s_axis_tuser;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [1:0]        m_axis_tuser;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tuser,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tuser
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tuser,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tuser
  );
endinterface

// File: rtl/demod_decimator.sv
// Per-channel integrate-and-dump decimator: sums 2**LOG2_DECIM
// samples of each interleaved channel and emits their floored mean.
module demod_decimator #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DECIM = 4,
  parameter int N_CH       = 4
) (
  input  logic s_axis_aclk,
  input  logic s_axis_aresetn,
  input  logic clear,
  demod_decimator_if.slave axis
);
  localparam int AW = DATA_W + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] CNT_MAX = '1;
  localparam logic [LOG2_DECIM-1:0] CNT_ONE = LOG2_DECIM'(1);

  logic signed [AW-1:0]   acc_q [N_CH];
  logic signed [AW-1:0]   acc_d [N_CH];
  logic signed [AW-1:0]   sum_w [N_CH];
  logic [LOG2_DECIM-1:0]  cnt_q [N_CH];
  logic [LOG2_DECIM-1:0]  cnt_d [N_CH];

  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [1:0]        tuser_q, tuser_d;
  logic              tvalid_q, tvalid_d;

  logic              s_ready;
  logic              accept;
  logic              legal;
  logic signed [AW-1:0] x;

  // Any beat stalls while the output is blocked, so channel
  // order on the output always follows input order.
  assign s_ready = !tvalid_q || axis.m_axis_tready;
  assign accept  = axis.s_axis_tvalid && s_ready;
  assign legal   = {30'd0, axis.s_axis_tuser} < N_CH;
  assign x = {{LOG2_DECIM{axis.s_axis_tdata[DATA_W-1]}},
              axis.s_axis_tdata};

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tdata  = tdata_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tuser  = tuser_q;

  always_comb begin
    tvalid_d = tvalid_q && !axis.m_axis_tready;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    for (int c = 0; c < N_CH; c++) begin
      sum_w[c] = acc_q[c] + x;
      acc_d[c] = clear ? '0 : acc_q[c];
      cnt_d[c] = clear ? '0 : cnt_q[c];
      if (accept && legal && axis.s_axis_tuser == 2'(c)) begin
        unique case (1'b1)
          clear: begin
            acc_d[c] = x;
            cnt_d[c] = CNT_ONE;
          end
          (cnt_q[c] == CNT_MAX): begin
            acc_d[c] = '0;
            cnt_d[c] = '0;
            // Arithmetic shift == keeping the upper DATA_W bits.
            tdata_d  = sum_w[c][AW-1:LOG2_DECIM];
            tuser_d  = 2'(c);
            tvalid_d = 1'b1;
          end
          default: begin
            acc_d[c] = sum_w[c];
            cnt_d[c] = cnt_q[c] + CNT_ONE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      tdata_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c] <= acc_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_demod_decimator.sv
// Directed bench for demod_decimator: vector table for steady-state
// windows, hand sequences for backpressure, clear and reset.
module tb_demod_decimator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  int out_sum = 0;

  always #5 clk = ~clk;

  demod_decimator_if #(.DATA_W(24)) bus ();

  demod_decimator #(
    .DATA_W(24),
    .LOG2_DECIM(4),
    .N_CH(4)
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_aresetn(rst_n),
    .clear(clr),
    .axis(bus)
  );

  always @(posedge clk)
    if (bus.m_axis_tvalid && bus.m_axis_tready)
      out_sum <= out_sum + int'($signed(bus.m_axis_tdata));

  typedef struct {
    logic       v;
    int         d;
    logic [1:0] u;
    logic       ev;
    int         ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] u, input int d,
                     input logic ev, input int ed);
    vec_t t;
    t.v = 1'b1; t.d = d; t.u = u; t.ev = ev; t.ed = ed;
    tbl.push_back(t);
  endtask

  task automatic idle();
    vec_t t;
    t.v = 1'b0; t.d = 0; t.u = 2'd0; t.ev = 1'b0; t.ed = 0;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input int d, input logic [1:0] u,
                     input logic c, input logic mr);
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d[23:0];
    bus.s_axis_tuser  = u;
    clr               = c;
    bus.m_axis_tready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ev,
                         input int ed, input int eu);
    chk({nm, "_val"}, int'(bus.m_axis_tvalid), int'(ev));
    if (ev) begin
      chk({nm, "_dat"}, int'($signed(bus.m_axis_tdata)), ed);
      chk({nm, "_usr"}, int'(bus.m_axis_tuser), eu);
    end
  endtask

  int s0;

  initial begin
    for (int i = 0; i < 15; i++) add(0, 1000, 0, 0);
    add(0, 1000, 1, 1000); idle();
    for (int i = 0; i < 15; i++) add(1, -1, 0, 0);
    add(1, 0, 1, -1); idle();
    for (int i = 0; i < 15; i++) add(1, 1, 0, 0);
    add(1, 0, 1, 0); idle();
    for (int i = 0; i < 15; i++) add(2, 8388607, 0, 0);
    add(2, 8388607, 1, 8388607); idle();
    for (int i = 0; i < 15; i++) add(3, -8388608, 0, 0);
    add(3, -8388608, 1, -8388608); idle();
    for (int i = 0; i < 64; i++)
      add(2'(i % 4), 10 * (i % 4 + 1), i >= 60, 10 * (i % 4 + 1));
    idle();

    drv(0, 0, 0, 0, 1);
    #1;
    chk_out("rst0", 1'b0, 0, 0);
    chk("rst0_dat", int'(bus.m_axis_tdata), 0);
    chk("rst0_usr", int'(bus.m_axis_tuser), 0);
    chk("rst0_srdy", int'(bus.s_axis_tready), 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drv(tbl[i].v, tbl[i].d, tbl[i].u, 0, 1);
      #1;
      chk("tbl_srdy", int'(bus.s_axis_tready), 1);
      tick();
      chk_out("tbl", tbl[i].ev, tbl[i].ed, int'(tbl[i].u));
    end

    // Backpressure: stall right after the ch0 dump
    s0 = out_sum;
    for (int i = 0; i < 61; i++) begin
      drv(1, 10 * (i % 4 + 1), 2'(i % 4), 0, 1);
      tick();
    end
    chk_out("bp_first", 1'b1, 10, 0);
    drv(1, 20, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_srdy", int'(bus.s_axis_tready), 0);
      tick();
      chk_out("bp_hold", 1'b1, 10, 0);
    end
    drv(1, 20, 1, 0, 1);
    tick();
    chk_out("bp_rel1", 1'b1, 20, 1);
    drv(1, 30, 2, 0, 1);
    tick();
    chk_out("bp_rel2", 1'b1, 30, 2);
    drv(1, 40, 3, 0, 1);
    tick();
    chk_out("bp_rel3", 1'b1, 40, 3);
    drv(0, 0, 0, 0, 1);
    tick();
    chk_out("bp_idle", 1'b0, 0, 0);
    chk("bp_sum", out_sum - s0, 100);

    // clear mid-window, with a partial ch1 window left open
    for (int i = 0; i < 8; i++) begin
      drv(1, 500, 0, 0, 1);
      tick();
    end
    drv(1, 100, 0, 1, 1);
    tick();
    chk_out("clr_beat", 1'b0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drv(1, 100, 0, 0, 1);
      tick();
      chk_out("clr_win", 1'b0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      drv(1, 9, 1, 0, 1);
      tick();
    end
    drv(1, 100, 0, 0, 1);
    tick();
    chk_out("clr_dump", 1'b1, 100, 0);
    drv(0, 0, 0, 0, 0);
    tick();
    chk_out("clr_held", 1'b1, 100, 0);

    // Asynchronous reset with output pending and ch1 mid-window
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_val", int'(bus.m_axis_tvalid), 0);
    chk("ar_dat", int'(bus.m_axis_tdata), 0);
    chk("ar_usr", int'(bus.m_axis_tuser), 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv(1, 7, 1, 0, 1);
      tick();
      chk_out("ar_win", i == 15, 7, 1);
    end
    drv(0, 0, 0, 0, 1);
    tick();
    chk_out("ar_idle", 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
